vcxo_host_link: RTL and testbench
=================================

VCXO_HOST_LINK -- requirements
Module: vcxo_host_link

Interface
REQ-001 Parameters SHALL be: FRAME_BITS, default 40, bits per host frame; CMD_WR_CORR, default 8'h01, write-correction opcode; SYNC_BYTE, default 8'hA5, first MISO byte; LOCK_CYCLES, default 1024, clk_in cycles with zero error before the locked flag sets.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
REQ-003 clk_in  input  1  single system clock; every flop in this block uses it.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 spi_sck  input  1  host SPI clock, mode 0, asynchronous to clk_in, at most clk_in/8.
REQ-006 spi_cs_n  input  1  host chip select, active low, asynchronous.
REQ-007 spi_mosi  input  1  host data in, MSB first.
REQ-008 spi_miso  output  1  status data out, MSB first.
REQ-009 freq_error  input  32 signed  measured VCXO error from the discipline loop.
REQ-010 PWM  input  32 signed  current pump duty word from the discipline loop.
REQ-011 VCXO_correction  output  16 signed  registered correction word, fed to the discipline loop.
REQ-012 corr_strobe  output  1  one-cycle pulse on each VCXO_correction update.
REQ-013 locked  output  1  high when freq_error has held 0 for LOCK_CYCLES cycles.
REQ-014 frame_err_cnt  output  8  saturating count of rejected frames.

Function
REQ-015 spi_sck, spi_cs_n and spi_mosi SHALL each pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized values, one clk_in cycle apart.
REQ-016 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 IDLE -> SHIFT on a synchronized cs_n falling edge. On that same cycle: bit counter = 0; freq_error and PWM are snapshotted into the TX shift register.
REQ-018 TX word = {SYNC_BYTE, sat16(freq_error), clamp16(PWM)}.
REQ-019 sat16 SHALL saturate: above 32767 -> 16'h7FFF; below -32768 -> 16'h8000.
REQ-020 clamp16 SHALL map negative values -> 0 and values above 65535 -> 16'hFFFF.
REQ-021 In SHIFT, each synchronized sck rising edge SHALL shift the synchronized mosi into the RX register and increment the bit counter.
REQ-022 In SHIFT, each sck falling edge SHALL advance the TX register by one bit.
REQ-023 spi_miso SHALL equal TX register MSB while in SHIFT with bit counter < FRAME_BITS, and 0 otherwise.
REQ-024 SHIFT -> DONE on a synchronized cs_n rising edge.
REQ-025 In DONE, a frame with bit count == FRAME_BITS and RX[39:32] == CMD_WR_CORR SHALL load VCXO_correction = RX[31:16] and pulse corr_strobe for exactly one cycle.
REQ-026 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-027 Latency: corr_strobe SHALL assert within 4 clk_in cycles of the spi_cs_n pin rising.
REQ-028 A bit count != FRAME_BITS at cs_n rising (short frame or over-clocked frame) SHALL discard the frame and increment frame_err_cnt, saturating at 255.
REQ-029 A full-length frame with an unknown opcode SHALL be silently ignored: no update and no error count.
REQ-030 Bit counter SHALL saturate at FRAME_BITS+1; it SHALL NOT wrap.
REQ-031 sck edges while in IDLE or DONE SHALL be ignored.
REQ-032 A cs_n falling edge coincident with DONE SHALL be honoured on the next IDLE cycle; it SHALL NOT be lost.
REQ-033 Lock counter SHALL increment while freq_error == 0 and clear on any nonzero value.
REQ-034 locked SHALL be 1 once the lock counter reaches LOCK_CYCLES, and 0 on the first cycle freq_error is nonzero.

Reset
REQ-035 On reset_in: state = IDLE; VCXO_correction = 0; corr_strobe = 0; spi_miso = 0; locked = 0; frame_err_cnt = 0; lock counter and bit counter = 0; shift registers cleared.
REQ-036 Reset mid-frame SHALL abort the frame without a correction update.
REQ-037 After reset, the block SHALL require the synchronized cs_n to be observed high before it accepts a new falling edge.

Verification
REQ-038 40-bit frame with MOSI = 01_FF38_0000 -> VCXO_correction = -200 and one corr_strobe pulse, within 4 cycles of cs_n rising.
REQ-039 freq_error = 40000, PWM = -5 at cs_n fall -> MISO = A5_7FFF_0000, even if both inputs change mid-frame.
REQ-040 39-bit frame, then 41-bit frame -> no corr_strobe; frame_err_cnt = 2; VCXO_correction unchanged.
REQ-041 Full frame with opcode 8'h7E -> no update; frame_err_cnt unchanged.
REQ-042 freq_error = 0 for 1024 cycles -> locked = 1; one cycle of freq_error = 3 -> locked = 0 on the next cycle.
REQ-043 reset_in asserted at bit 20 while cs_n is held low -> no update; new frame ignored until cs_n goes high and then low; all outputs equal reset values.

Source files
------------

// File: rtl/vcxo_host_link.sv
// vcxo_host_link: SPI slave bridge between the host and the VCXO discipline loop.
// The host writes 16-bit correction words and reads back a status frame with
// saturated frequency error and clamped pump duty. It also provides a lock
// detector on the measured frequency error.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a chip-select falling edge
// SHIFT | frame in progress, sck edges move RX/TX data
// DONE  | one-cycle frame close, correction/error result is visible
module vcxo_host_link #(
  parameter int         FRAME_BITS  = 40,
  parameter logic [7:0] CMD_WR_CORR = 8'h01,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         LOCK_CYCLES = 1024
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               spi_sck,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  input  logic signed [31:0] freq_error,
  input  logic signed [31:0] PWM,
  output logic signed [15:0] VCXO_correction,
  output logic               corr_strobe,
  output logic               locked,
  output logic [7:0]         frame_err_cnt
);

  localparam int CNT_W  = $clog2(FRAME_BITS + 2);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]  FRAME_LEN = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]  HDR_LEN   = CNT_W'(24);
  localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;
  logic   pend, pend_nxt;
  logic   start_frame, end_frame;

  logic [1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_prev, cs_prev;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [23:0]       rx_hdr;
  logic [39:0]       tx_sr;
  logic [15:0]       fe16, pwm16;
  logic [LOCK_W-1:0] lock_cnt;

  // Synchronize SPI pins; reset value 0 on cs forces a high observation before any falling edge.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_prev  <= sck_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign sck_fall = ~sck_sync[1] & sck_prev;
  assign cs_rise  = cs_sync[1] & ~cs_prev;
  assign cs_fall  = ~cs_sync[1] & cs_prev;

  // State register plus the held-over cs falling edge seen during DONE.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= IDLE;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  // Next-state logic and frame start/end qualifiers.
  always_comb begin
    state_nxt   = state;
    pend_nxt    = pend;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall || pend) begin
          state_nxt   = SHIFT;
          start_frame = 1'b1;
          pend_nxt    = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = DONE;
          end_frame = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (cs_fall) pend_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status word fields: signed saturation of the error, unsigned clamp of the duty.
  always_comb begin
    if (freq_error > 32'sd32767)       fe16 = 16'h7FFF;
    else if (freq_error < -32'sd32768) fe16 = 16'h8000;
    else                               fe16 = freq_error[15:0];
    if (PWM < 32'sd0)                  pwm16 = 16'h0000;
    else if (PWM > 32'sd65535)         pwm16 = 16'hFFFF;
    else                               pwm16 = PWM[15:0];
  end

  // Frame datapath. Only the 24-bit header (opcode + correction) is kept from RX;
  // the decision is registered on the SHIFT->DONE edge so corr_strobe lines up with DONE.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      bit_cnt         <= '0;
      rx_hdr          <= '0;
      tx_sr           <= '0;
      VCXO_correction <= '0;
      corr_strobe     <= 1'b0;
      frame_err_cnt   <= '0;
    end else begin
      corr_strobe <= 1'b0;
      if (start_frame) begin
        bit_cnt <= '0;
        rx_hdr  <= '0;
        tx_sr   <= {SYNC_BYTE, fe16, pwm16};
      end else if (state == SHIFT) begin
        if (sck_rise) begin
          if (bit_cnt < HDR_LEN) rx_hdr <= {rx_hdr[22:0], mosi_sync[1]};
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
        end
        if (sck_fall) tx_sr <= {tx_sr[38:0], 1'b0};
      end
      if (end_frame) begin
        if (bit_cnt == FRAME_LEN) begin
          if (rx_hdr[23:16] == CMD_WR_CORR) begin
            VCXO_correction <= rx_hdr[15:0];
            corr_strobe     <= 1'b1;
          end
        end else if (frame_err_cnt != 8'hFF) begin
          frame_err_cnt <= frame_err_cnt + 8'd1;
        end
      end
    end
  end

  assign spi_miso = (state == SHIFT) && (bit_cnt < FRAME_LEN) && tx_sr[39];

  // Lock detector: count consecutive zero-error cycles, saturating at the lock threshold.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      lock_cnt <= '0;
    end else if (freq_error != 32'sd0) begin
      lock_cnt <= '0;
    end else if (lock_cnt != LOCK_MAX) begin
      lock_cnt <= lock_cnt + LOCK_W'(1);
    end
  end

  assign locked = (lock_cnt == LOCK_MAX);

endmodule

// File: tb/tb_vcxo_host_link.sv
// Bench for vcxo_host_link: directed SPI frames against a frame-level model,
// a per-cycle compare process, and literal expectations.
module tb_vcxo_host_link;

  localparam int LOCK = 1024;

  logic clk_in = 1'b0;
  logic reset_in;
  logic spi_sck, spi_cs_n, spi_mosi, spi_miso;
  logic signed [31:0] freq_error, PWM;
  logic signed [15:0] VCXO_correction;
  logic corr_strobe, locked;
  logic [7:0] frame_err_cnt;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int zc = 0;
  logic quiet = 1'b0;
  logic chk_on = 1'b0;
  logic [15:0] m_corr = 16'h0000;
  logic [7:0]  m_err = 8'd0;
  logic [39:0] cap;

  vcxo_host_link dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .freq_error(freq_error), .PWM(PWM),
    .VCXO_correction(VCXO_correction), .corr_strobe(corr_strobe),
    .locked(locked), .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #900_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected status frame from plain integer saturation/clamp rules.
  function automatic logic [39:0] exp_tx(input int fe, input int pwm);
    logic [15:0] a, b;
    if (fe > 32767)       a = 16'h7FFF;
    else if (fe < -32768) a = 16'h8000;
    else                  a = fe[15:0];
    if (pwm < 0)          b = 16'h0000;
    else if (pwm > 65535) b = 16'hFFFF;
    else                  b = pwm[15:0];
    return {8'hA5, a, b};
  endfunction

  // Lock model: consecutive zero-error samples.
  always @(posedge clk_in) begin
    if (reset_in) zc = 0;
    else if (freq_error == 0) begin
      if (zc < LOCK) zc = zc + 1;
    end else zc = 0;
  end

  // Per-cycle compare against the model; frame outputs only while the link is quiet.
  always @(negedge clk_in) begin
    if (chk_on) begin
      if (corr_strobe) strobe_cnt++;
      check("locked_cycle", {63'd0, locked}, {63'd0, (zc >= LOCK)});
      if (quiet) begin
        check("corr_cycle", {48'd0, $unsigned(VCXO_correction)}, {48'd0, m_corr});
        check("err_cycle", {56'd0, frame_err_cnt}, {56'd0, m_err});
        check("miso_idle", {63'd0, spi_miso}, 64'd0);
        check("strobe_idle", {63'd0, corr_strobe}, 64'd0);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_in);
    #3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_corr"}, {48'd0, $unsigned(VCXO_correction)}, 64'd0);
    check({tag, "_strobe"}, {63'd0, corr_strobe}, 64'd0);
    check({tag, "_miso"}, {63'd0, spi_miso}, 64'd0);
    check({tag, "_locked"}, {63'd0, locked}, 64'd0);
    check({tag, "_err"}, {56'd0, frame_err_cnt}, 64'd0);
  endtask

  // mid: 0 plain, 1 change loop inputs at bit 20, 2 reset at bit 20
  task automatic spi_frame(input logic [47:0] data, input int nbits, input int mid,
                           output logic [39:0] c_out);
    logic [47:0] c;
    c = '0;
    quiet = 1'b0;
    strobe_cnt = 0;
    spi_cs_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = data[nbits-1-i];
      if (i == 20 && mid == 1) begin
        freq_error = 123;
        PWM = 777;
      end
      if (i == 20 && mid == 2) begin
        reset_in = 1'b1;
        wait_clk(3);
        reset_in = 1'b0;
        #1;
        check_reset_outputs("midreset");
        #2;
      end
      wait_clk(6);
      c = {c[46:0], spi_miso};
      spi_sck = 1'b1;
      wait_clk(6);
      spi_sck = 1'b0;
    end
    wait_clk(6);
    spi_cs_n = 1'b1;
    c_out = c[39:0];
  endtask

  task automatic do_frame(input logic [47:0] data, input int nbits, input int mid,
                          input string tag, output logic [39:0] c_out);
    logic [39:0] exp_miso;
    logic wr;
    int lat;
    exp_miso = exp_tx(freq_error, PWM);
    spi_frame(data, nbits, mid, c_out);
    wr = (mid != 2) && (nbits == 40) && (data[39:32] == 8'h01);
    if (mid == 2) begin
      m_corr = 16'h0000;
      m_err = 8'd0;
    end else if (nbits != 40) begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else if (wr) begin
      m_corr = data[31:16];
    end
    if (mid != 2 && nbits == 40) check({tag, "_miso"}, {24'd0, c_out}, {24'd0, exp_miso});
    if (wr) begin
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk_in);
        #1;
        if (corr_strobe) begin
          lat = k;
          break;
        end
      end
      checks++;
      if (lat < 1 || lat > 4) begin
        errors++;
        $display("FAIL %s_latency actual=%0d cycles required=1..4", tag, lat);
      end
    end
    wait_clk(8);
    check({tag, "_strobes"}, strobe_cnt, wr ? 64'd1 : 64'd0);
    quiet = 1'b1;
  endtask

  initial begin
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    freq_error = 5;
    PWM = 0;
    reset_in = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    #2;
    reset_in = 1'b0;
    chk_on = 1'b1;
    wait_clk(8);
    quiet = 1'b1;

    // write -200 while status inputs saturate and change mid-frame
    freq_error = 40000;
    PWM = -5;
    do_frame(48'h01_FF38_0000, 40, 1, "wr_m200", cap);
    check("miso_lit_a", {24'd0, cap}, {24'd0, 40'hA5_7FFF_0000});
    check("corr_lit_m200", {48'd0, $unsigned(VCXO_correction)}, 64'hFF38);

    freq_error = -100000;
    PWM = 70000;
    do_frame(48'h01_1234_ABCD, 40, 0, "wr_1234", cap);
    check("miso_lit_b", {24'd0, cap}, {24'd0, 40'hA5_8000_FFFF});
    check("corr_lit_1234", {48'd0, $unsigned(VCXO_correction)}, 64'h1234);

    freq_error = -3;
    PWM = 300;
    do_frame(48'h01_8000_0000, 40, 0, "wr_min", cap);
    check("miso_lit_c", {24'd0, cap}, {24'd0, 40'hA5_FFFD_012C});

    // short then over-long frames
    do_frame(48'h00_00FF_3800, 39, 0, "short39", cap);
    do_frame(48'h01_01FF_3800, 41, 0, "long41", cap);
    check("err_lit_2", {56'd0, frame_err_cnt}, 64'd2);
    check("corr_lit_kept", {48'd0, $unsigned(VCXO_correction)}, 64'h8000);

    // unknown opcode
    do_frame(48'h7E_4444_0000, 40, 0, "op7e", cap);
    check("err_lit_op7e", {56'd0, frame_err_cnt}, 64'd2);
    check("corr_lit_op7e", {48'd0, $unsigned(VCXO_correction)}, 64'h8000);

    // lock detector
    freq_error = 0;
    repeat (1023) @(posedge clk_in);
    #1;
    check("lock_lit_1023", {63'd0, locked}, 64'd0);
    @(posedge clk_in);
    #1;
    check("lock_lit_1024", {63'd0, locked}, 64'd1);
    #2;
    freq_error = 3;
    @(posedge clk_in);
    #1;
    check("lock_lit_drop", {63'd0, locked}, 64'd0);
    #2;
    freq_error = 0;
    wait_clk(4);

    // reset in the middle of a write frame, cs held low
    do_frame(48'h01_0BAD_0000, 40, 2, "rst_mid", cap);
    check("corr_lit_after_rst", {48'd0, $unsigned(VCXO_correction)}, 64'd0);
    check("err_lit_after_rst", {56'd0, frame_err_cnt}, 64'd0);

    // next proper frame after cs went high is accepted
    do_frame(48'h01_0055_0000, 40, 0, "wr_0055", cap);
    check("corr_lit_0055", {48'd0, $unsigned(VCXO_correction)}, 64'h0055);
    wait_clk(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
